vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator; next generation of the fixed 800x600 timing block.
//  Any resolution/porch set by parameter, selectable sync polarity, pixel clock-enable input,

---
 rtl/vga_timing_gen.sv | 119 +++++++++++
 tb/tb_vga_timing_gen.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator (counters, blanking, sync, strobes)
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 800,
    parameter int H_FP      = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BP      = 88,
    parameter int V_ACTIVE  = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 23,
    parameter int HSYNC_POL = 1,
    parameter int VSYNC_POL = 1,
    parameter int CNT_W     = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hblnk,
    output logic             vblnk,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start,
    output logic [15:0]      frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic             HS_ON      = (HSYNC_POL != 0);
    localparam logic             VS_ON      = (VSYNC_POL != 0);

    generate
        if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
            V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
            $error("vga_timing_gen: timing parameters must all be non-zero");
        end
        if (CNT_W < 1 || CNT_W > 30 ||
            (H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_bad_width
            $error("vga_timing_gen: CNT_W cannot hold H_TOTAL-1 / V_TOTAL-1");
        end
    endgenerate

    logic             h_wrap;
    logic             v_wrap;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             hsync_act;
    logic             vsync_act;

    // Flags are derived from the next counter value so they line up with hcount/vcount.
    always_comb begin
        h_wrap = (hcount == H_LAST);
        v_wrap = (vcount == V_LAST);
        h_nxt  = hcount;
        v_nxt  = vcount;
        if (en) begin
            if (h_wrap) begin
                h_nxt = '0;
                v_nxt = v_wrap ? '0 : vcount + CNT_W'(1);
            end else begin
                h_nxt = hcount + CNT_W'(1);
            end
        end
        hsync_act = (h_nxt >= HS_START) && (h_nxt < HS_END);
        vsync_act = (v_nxt >= VS_START) && (v_nxt < VS_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount      <= '0;
            vcount      <= '0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            hblnk       <= (h_nxt >= H_ACT_END);
            vblnk       <= (v_nxt >= V_ACT_END);
            hsync       <= hsync_act ? HS_ON : ~HS_ON;
            vsync       <= vsync_act ? VS_ON : ~VS_ON;
            line_start  <= en && h_wrap;
            frame_start <= en && h_wrap && v_wrap;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Advances on the same edge that raises frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (en && h_wrap && v_wrap) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard testbench for vga_timing_gen (small, inverted-polarity and default instances)
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3, HT = 16;
    localparam int VA = 6, VF = 1, VS = 2, VB = 2, VT = 11;
    localparam int CW = 5;
    localparam int DHT = 1056, DVT = 628;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    logic [CW-1:0] hcount, vcount, hcount_n, vcount_n;
    logic          hblnk, vblnk, hsync, vsync, line_start, frame_start;
    logic          hblnk_n, vblnk_n, hsync_n, vsync_n, line_start_n, frame_start_n;
    logic [15:0]   frame_cnt, frame_cnt_n, frame_cnt_d;
    logic [10:0]   hcount_d, vcount_d;
    logic          hblnk_d, vblnk_d, hsync_d, vsync_d, line_start_d, frame_start_d;

    vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .HSYNC_POL(1), .VSYNC_POL(1), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .hcount(hcount), .vcount(vcount),
        .hblnk(hblnk), .vblnk(vblnk), .hsync(hsync), .vsync(vsync),
        .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt));

    vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .HSYNC_POL(0), .VSYNC_POL(0), .CNT_W(CW)) dut_n (
        .clk(clk), .rst_n(rst_n), .en(en), .hcount(hcount_n), .vcount(vcount_n),
        .hblnk(hblnk_n), .vblnk(vblnk_n), .hsync(hsync_n), .vsync(vsync_n),
        .line_start(line_start_n), .frame_start(frame_start_n), .frame_cnt(frame_cnt_n));

    vga_timing_gen dut_d (
        .clk(clk), .rst_n(rst_n), .en(en), .hcount(hcount_d), .vcount(vcount_d),
        .hblnk(hblnk_d), .vblnk(vblnk_d), .hsync(hsync_d), .vsync(vsync_d),
        .line_start(line_start_d), .frame_start(frame_start_d), .frame_cnt(frame_cnt_d));

    always #5 clk = ~clk;

    typedef struct {
        int h; int v; bit hb; bit vb; bit hs; bit vs; bit ls; bit fs; int fc;
        int dh; int dv; bit dhb; bit dvb; bit dhs; bit dvs; bit dls;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int mh, mv, mfc, dh, dv;
    int n_vec = 0;
    int n_err = 0;

    task automatic adv(input bit step_en, input int ht, input int vt,
                       inout int h, inout int v, output bit ls, output bit fs);
        ls = 1'b0;
        fs = 1'b0;
        if (step_en) begin
            h = h + 1;
            if (h == ht) begin
                h  = 0;
                ls = 1'b1;
                v  = v + 1;
                if (v == vt) begin
                    v  = 0;
                    fs = 1'b1;
                end
            end
        end
    endtask

    function automatic exp_t mk(input bit ls, input bit fs, input bit dls);
        exp_t x;
        x.h   = mh;
        x.v   = mv;
        x.hb  = (mh >= HA);
        x.vb  = (mv >= VA);
        x.hs  = (mh >= HA + HF) && (mh < HA + HF + HS);
        x.vs  = (mv >= VA + VF) && (mv < VA + VF + VS);
        x.ls  = ls;
        x.fs  = fs;
`ifdef VGA_TIMING_FRAME_CNT_EN
        x.fc  = mfc % 65536;
`else
        x.fc  = 0;
`endif
        x.dh  = dh;
        x.dv  = dv;
        x.dhb = (dh >= 800);
        x.dvb = (dv >= 600);
        x.dhs = (dh >= 840) && (dh <= 967);
        x.dvs = (dv >= 601) && (dv <= 604);
        x.dls = dls;
        return x;
    endfunction

    task automatic model_reset();
        mh = 0; mv = 0; mfc = 0; dh = 0; dv = 0;
    endtask

    task automatic push_step(input bit step_en);
        bit ls, fs, dls, dfs;
        en = step_en;
        adv(step_en, HT, VT, mh, mv, ls, fs);
        adv(step_en, DHT, DVT, dh, dv, dls, dfs);
        if (fs) mfc = mfc + 1;
        sbq.push_back(mk(ls, fs, dls));
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            sbq.push_back(mk(1'b0, 1'b0, 1'b0));
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            n_vec++;
            if ({hcount, vcount, hblnk, vblnk, hsync, vsync, line_start, frame_start, frame_cnt} !==
                {CW'(e.h), CW'(e.v), e.hb, e.vb, 1'b0, 1'b0, e.ls, e.fs, 16'(e.fc)}) begin
                n_err++;
                $display("FAIL reset_state cyc%0d got h=%0d v=%0d flags=%b fc=%0d want h=0 v=0 flags=000000 fc=0",
                         i, hcount, vcount, {hblnk, vblnk, hsync, vsync, line_start, frame_start}, frame_cnt);
            end
            n_vec++;
            if ({hsync_n, vsync_n} !== 2'b11) begin
                n_err++;
                $display("FAIL reset_sync_neg got %b want 11", {hsync_n, vsync_n});
            end
            n_vec++;
            if ({hcount_d, vcount_d, hsync_d, line_start_d} !== {11'd0, 11'd0, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL reset_default got h=%0d v=%0d hs=%b ls=%b want 0 0 0 0",
                         hcount_d, vcount_d, hsync_d, line_start_d);
            end
        end
        rst_n = 1'b1;
        push_step(1'b1);
        e = sbq.pop_front();
        n_vec++;
        if ({hcount, line_start, frame_start} !== {CW'(e.h), e.ls, e.fs}) begin
            n_err++;
            $display("FAIL reset_release got h=%0d ls=%b fs=%b want h=%0d ls=%b fs=%b",
                     hcount, line_start, frame_start, e.h, e.ls, e.fs);
        end
    endtask

    task automatic test_line();
        apply_reset();
        for (int i = 0; i < DHT + 2; i++) begin
            push_step(1'b1);
            e = sbq.pop_front();
            n_vec++;
            if ({hcount_d, vcount_d, hblnk_d, vblnk_d, hsync_d, vsync_d, line_start_d} !==
                {11'(e.dh), 11'(e.dv), e.dhb, e.dvb, e.dhs, e.dvs, e.dls}) begin
                n_err++;
                $display("FAIL line h=%0d v=%0d hb/vb/hs/vs/ls=%b want h=%0d v=%0d %b",
                         hcount_d, vcount_d, {hblnk_d, vblnk_d, hsync_d, vsync_d, line_start_d},
                         e.dh, e.dv, {e.dhb, e.dvb, e.dhs, e.dvs, e.dls});
            end
        end
    endtask

    task automatic test_frames();
        int fs_seen, first_fs, last_fs;
        fs_seen = 0; first_fs = -1; last_fs = -1;
        apply_reset();
        for (int i = 0; i < 2 * HT * VT; i++) begin
            push_step(1'b1);
            e = sbq.pop_front();
            n_vec++;
            if ({hcount, vcount, hblnk, vblnk, hsync, vsync, line_start, frame_start, frame_cnt} !==
                {CW'(e.h), CW'(e.v), e.hb, e.vb, e.hs, e.vs, e.ls, e.fs, 16'(e.fc)}) begin
                n_err++;
                $display("FAIL frame h=%0d v=%0d flags=%b fc=%0d want h=%0d v=%0d flags=%b fc=%0d",
                         hcount, vcount, {hblnk, vblnk, hsync, vsync, line_start, frame_start}, frame_cnt,
                         e.h, e.v, {e.hb, e.vb, e.hs, e.vs, e.ls, e.fs}, e.fc);
            end
            if (frame_start === 1'b1) begin
                fs_seen++;
                if (first_fs < 0) first_fs = i;
                last_fs = i;
            end
        end
        n_vec++;
        if (fs_seen !== 2 || (last_fs - first_fs) !== HT * VT) begin
            n_err++;
            $display("FAIL frame_period got count=%0d spacing=%0d want count=2 spacing=%0d",
                     fs_seen, last_fs - first_fs, HT * VT);
        end
    endtask

    task automatic test_polarity();
        apply_reset();
        for (int i = 0; i < HT * VT; i++) begin
            push_step(1'b1);
            e = sbq.pop_front();
            n_vec++;
            if ({hcount_n, vcount_n, hsync_n, vsync_n} !== {CW'(e.h), CW'(e.v), ~e.hs, ~e.vs}) begin
                n_err++;
                $display("FAIL polarity h=%0d v=%0d hs=%b vs=%b want h=%0d v=%0d hs=%b vs=%b",
                         hcount_n, vcount_n, hsync_n, vsync_n, e.h, e.v, ~e.hs, ~e.vs);
            end
        end
    endtask

    task automatic test_en_toggle();
        apply_reset();
        for (int i = 0; i < 2 * HT * VT + 40; i++) begin
            push_step(i % 2 == 0);
            e = sbq.pop_front();
            n_vec++;
            if ({hcount, vcount, hsync, vblnk, line_start, frame_start, line_start_d} !==
                {CW'(e.h), CW'(e.v), e.hs, e.vb, e.ls, e.fs, e.dls}) begin
                n_err++;
                $display("FAIL en_toggle en=%b h=%0d v=%0d hs/vb/ls/fs=%b want h=%0d v=%0d %b",
                         en, hcount, vcount, {hsync, vblnk, line_start, frame_start},
                         e.h, e.v, {e.hs, e.vb, e.ls, e.fs});
            end
        end
    endtask

    task automatic test_mid_reset();
        int guard;
        apply_reset();
        for (int i = 0; i < HT * VT; i++) begin
            push_step(1'b1);
            void'(sbq.pop_front());
        end
        guard = 0;
        while (!(mh == 10 && mv == 4) && guard < 2 * HT * VT) begin
            push_step(1'b1);
            e = sbq.pop_front();
            guard++;
            n_vec++;
            if ({hcount, vcount, frame_cnt} !== {CW'(e.h), CW'(e.v), 16'(e.fc)}) begin
                n_err++;
                $display("FAIL mid_run h=%0d v=%0d fc=%0d want h=%0d v=%0d fc=%0d",
                         hcount, vcount, frame_cnt, e.h, e.v, e.fc);
            end
        end
        n_vec++;
        if (guard >= 2 * HT * VT) begin
            n_err++;
            $display("FAIL mid_reset_reach got h=%0d v=%0d want h=10 v=4", mh, mv);
        end
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        sbq.push_back(mk(1'b0, 1'b0, 1'b0));
        #1;
        e = sbq.pop_front();
        n_vec++;
        if ({hcount, vcount, hblnk, vblnk, hsync, vsync, line_start, frame_start, frame_cnt, hsync_n, vsync_n} !==
            {CW'(e.h), CW'(e.v), e.hb, e.vb, 1'b0, 1'b0, 1'b0, 1'b0, 16'(e.fc), 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL async_reset got h=%0d v=%0d flags=%b fc=%0d want h=0 v=0 flags=000000 fc=0",
                     hcount, vcount, {hblnk, vblnk, hsync, vsync, line_start, frame_start}, frame_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_line();
        test_frames();
        test_polarity();
        test_en_toggle();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
